// File: rtl/coin_accumulator.sv
// Coin front-end for the vending FSM: accumulates credit, runs select/vend-ack, returns change or refunds.
// Optional idle auto-refund is built when COIN_TIMEOUT_EN is defined.
module coin_accumulator #(
    parameter int unsigned MAX_CREDIT     = 30,
    parameter int unsigned PRICE_1        = 5,
    parameter int unsigned PRICE_2        = 10,
    parameter int unsigned PRICE_3        = 15,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel_prod,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic [5:0] amount,
    output logic [1:0] product,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [5:0] change_amt,
    output logic       insufficient,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_SELECT   = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] credit_q, credit_d;
    logic [1:0] prod_q, prod_d;
    logic       coin_reject_q, coin_reject_d;
    logic       change_valid_q, change_valid_d;
    logic [5:0] change_amt_q, change_amt_d;
    logic       insufficient_q, insufficient_d;

    logic [5:0] coin_val;
    logic [5:0] coin_sum;
    logic [5:0] price;
    logic       sel_ok;
    logic       timeout_hit;
    logic       refund_req;
    logic       coin_acc;

`ifdef COIN_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    assign timeout_hit = (state_q == S_COLLECT) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign timeout_hit = 1'b0;
    assign unused_cfg  = ^{32'(TIMEOUT_CYCLES), coin_acc};
`endif

    always_comb begin
        coin_val = 6'd1;
        case (coin_type)
            2'b00: coin_val = 6'd1;
            2'b01: coin_val = 6'd2;
            2'b10: coin_val = 6'd5;
            2'b11: coin_val = 6'd10;
            default: coin_val = 6'd1;
        endcase
        price = 6'(PRICE_1);
        case (prod_q)
            2'b10:   price = 6'(PRICE_2);
            2'b11:   price = 6'(PRICE_3);
            default: price = 6'(PRICE_1);
        endcase
    end

    assign coin_sum   = credit_q + coin_val;
    assign sel_ok     = sel_valid && (sel_prod != 2'b00) && (credit_q != 6'd0);
    // A timeout coinciding with cancel funnels into the same single refund.
    assign refund_req = (state_q == S_COLLECT) && (cancel || timeout_hit);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        prod_d         = prod_q;
        coin_reject_d  = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        insufficient_d = 1'b0;
        coin_acc       = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (refund_req) begin
                    state_d        = S_REFUND;
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = 6'd0;
                    coin_reject_d  = coin_valid;
                end else if (sel_ok) begin
                    state_d       = S_SELECT;
                    prod_d        = sel_prod;
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (!cancel && (coin_sum <= 6'(MAX_CREDIT))) begin
                        credit_d = coin_sum;
                        state_d  = S_COLLECT;
                        coin_acc = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                state_d       = S_WAIT_ACK;
                coin_reject_d = coin_valid;
            end
            S_WAIT_ACK: begin
                coin_reject_d = coin_valid;
                if (vend_ack) begin
                    // Change comes from our own 6-bit credit, not the vend FSM balance.
                    change_amt_d   = credit_q - price;
                    change_valid_d = 1'b1;
                    credit_d       = 6'd0;
                    state_d        = S_IDLE;
                end else begin
                    insufficient_d = 1'b1;
                    state_d        = S_COLLECT;
                end
            end
            S_REFUND: begin
                coin_reject_d = coin_valid;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef COIN_TIMEOUT_EN
    always_comb begin
        cnt_d = 16'd0;
        if ((state_q == S_COLLECT) && !coin_acc && !sel_ok && !refund_req)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= 6'd0;
            prod_q         <= 2'b00;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= 6'd0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            prod_q         <= prod_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            insufficient_q <= insufficient_d;
        end
    end

    assign amount       = credit_q;
    assign product      = (state_q == S_SELECT) ? prod_q : 2'b00;
    assign coin_reject  = coin_reject_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign insufficient = insufficient_q;
    assign busy         = (state_q == S_SELECT) || (state_q == S_WAIT_ACK) || (state_q == S_REFUND);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator: reset, vend, insufficient, saturation, cancel and idle timeout.
module tb_coin_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_prod;
    logic       cancel;
    logic       vend_ack;
    logic [5:0] amount;
    logic [1:0] product;
    logic       coin_reject;
    logic       change_valid;
    logic [5:0] change_amt;
    logic       insufficient;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_COLLECT = 3'd1, ST_SELECT = 3'd2,
                           ST_WAIT = 3'd3, ST_REFUND = 3'd4;

    coin_accumulator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_prod(sel_prod), .cancel(cancel), .vend_ack(vend_ack),
        .amount(amount), .product(product), .coin_reject(coin_reject),
        .change_valid(change_valid), .change_amt(change_amt), .insufficient(insufficient),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0;
        sel_prod = 2'b00; cancel = 1'b0; vend_ack = 1'b0;
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] p);
        sel_valid = 1'b1; sel_prod = p;
        step();
        sel_valid = 1'b0; sel_prod = 2'b00;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (amount !== 6'd0 || state_dbg !== ST_IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL reset_init amount=%0d state=%0d busy=%0b exp 0/0/0", amount, state_dbg, busy); end
        coin(2'b11); coin(2'b01);
        checks++; if (amount !== 6'd12) begin
            errors++; $display("FAIL reset_pre_credit got %0d exp 12", amount); end
        #3 reset = 1'b0;
        #1;
        checks++; if (amount !== 6'd0 || coin_reject !== 1'b0 || change_valid !== 1'b0 ||
                      insufficient !== 1'b0 || product !== 2'b00 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL reset_async amount=%0d rej=%0b cv=%0b ins=%0b prod=%0d busy=%0b state=%0d exp all 0",
                               amount, coin_reject, change_valid, insufficient, product, busy, state_dbg); end
        @(negedge clk) reset = 1'b1;
        // reset while waiting for the vend ack
        coin(2'b10); select(2'b01); step();
        checks++; if (state_dbg !== ST_WAIT) begin
            errors++; $display("FAIL reset_reach_wait state=%0d exp %0d", state_dbg, ST_WAIT); end
        vend_ack = 1'b1;
        #2 reset = 1'b0;
        #1;
        step();
        vend_ack = 1'b0;
        checks++; if (change_valid !== 1'b0 || amount !== 6'd0 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL reset_mid_vend cv=%0b amount=%0d state=%0d exp 0/0/0", change_valid, amount, state_dbg); end
    endtask

    task automatic test_vend();
        do_reset();
        coin(2'b11); coin(2'b10);
        checks++; if (amount !== 6'd15 || state_dbg !== ST_COLLECT) begin
            errors++; $display("FAIL vend_credit amount=%0d state=%0d exp 15/1", amount, state_dbg); end
        select(2'b01);
        checks++; if (product !== 2'b01 || busy !== 1'b1 || state_dbg !== ST_SELECT) begin
            errors++; $display("FAIL vend_select prod=%0d busy=%0b state=%0d exp 1/1/2", product, busy, state_dbg); end
        step();
        checks++; if (product !== 2'b00 || amount !== 6'd15 || state_dbg !== ST_WAIT) begin
            errors++; $display("FAIL vend_wait prod=%0d amount=%0d state=%0d exp 0/15/3", product, amount, state_dbg); end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd10 || amount !== 6'd0 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL vend_change cv=%0b amt=%0d amount=%0d state=%0d exp 1/10/0/0",
                               change_valid, change_amt, amount, state_dbg); end
        step();
        checks++; if (change_valid !== 1'b0 || change_amt !== 6'd10) begin
            errors++; $display("FAIL vend_pulse cv=%0b amt=%0d exp 0/10", change_valid, change_amt); end
    endtask

    task automatic test_insufficient();
        do_reset();
        coin(2'b11); coin(2'b01);
        select(2'b11);
        checks++; if (product !== 2'b11) begin
            errors++; $display("FAIL insuf_prod got %0d exp 3", product); end
        step();
        step();
        checks++; if (insufficient !== 1'b1 || amount !== 6'd12 || state_dbg !== ST_COLLECT || change_valid !== 1'b0) begin
            errors++; $display("FAIL insuf_flag ins=%0b amount=%0d state=%0d cv=%0b exp 1/12/1/0",
                               insufficient, amount, state_dbg, change_valid); end
        step();
        checks++; if (insufficient !== 1'b0 || amount !== 6'd12) begin
            errors++; $display("FAIL insuf_pulse ins=%0b amount=%0d exp 0/12", insufficient, amount); end
    endtask

    task automatic test_saturation();
        do_reset();
        coin(2'b11); coin(2'b11); coin(2'b10);
        checks++; if (amount !== 6'd25 || coin_reject !== 1'b0) begin
            errors++; $display("FAIL sat_25 amount=%0d rej=%0b exp 25/0", amount, coin_reject); end
        coin(2'b11);
        checks++; if (coin_reject !== 1'b1 || amount !== 6'd25) begin
            errors++; $display("FAIL sat_reject rej=%0b amount=%0d exp 1/25", coin_reject, amount); end
        coin(2'b10);
        checks++; if (coin_reject !== 1'b0 || amount !== 6'd30) begin
            errors++; $display("FAIL sat_30 rej=%0b amount=%0d exp 0/30", coin_reject, amount); end
        coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || amount !== 6'd30) begin
            errors++; $display("FAIL sat_full rej=%0b amount=%0d exp 1/30", coin_reject, amount); end
        // coin with a valid select is rejected; coin while busy is rejected
        coin_valid = 1'b1; coin_type = 2'b00;
        select(2'b10);
        coin_valid = 1'b0;
        checks++; if (coin_reject !== 1'b1 || state_dbg !== ST_SELECT || amount !== 6'd30) begin
            errors++; $display("FAIL sel_coin rej=%0b state=%0d amount=%0d exp 1/2/30", coin_reject, state_dbg, amount); end
        coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || amount !== 6'd30 || state_dbg !== ST_WAIT) begin
            errors++; $display("FAIL busy_coin rej=%0b amount=%0d state=%0d exp 1/30/3", coin_reject, amount, state_dbg); end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd20) begin
            errors++; $display("FAIL sat_change cv=%0b amt=%0d exp 1/20", change_valid, change_amt); end
    endtask

    task automatic test_cancel();
        do_reset();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++; if (change_valid !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL cancel_idle cv=%0b state=%0d exp 0/0", change_valid, state_dbg); end
        select(2'b01);
        checks++; if (state_dbg !== ST_IDLE || product !== 2'b00) begin
            errors++; $display("FAIL sel_no_credit state=%0d prod=%0d exp 0/0", state_dbg, product); end
        coin(2'b10); coin(2'b01);
        select(2'b00);
        checks++; if (state_dbg !== ST_COLLECT || amount !== 6'd7) begin
            errors++; $display("FAIL sel_prod0 state=%0d amount=%0d exp 1/7", state_dbg, amount); end
        cancel = 1'b1;
        coin(2'b00);
        cancel = 1'b0;
        checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amt !== 6'd7 ||
                      amount !== 6'd0 || state_dbg !== ST_REFUND || busy !== 1'b1) begin
            errors++; $display("FAIL cancel_refund rej=%0b cv=%0b amt=%0d amount=%0d state=%0d busy=%0b exp 1/1/7/0/4/1",
                               coin_reject, change_valid, change_amt, amount, state_dbg, busy); end
        step();
        checks++; if (change_valid !== 1'b0 || state_dbg !== ST_IDLE || change_amt !== 6'd7) begin
            errors++; $display("FAIL cancel_done cv=%0b state=%0d amt=%0d exp 0/0/7", change_valid, state_dbg, change_amt); end
    endtask

    task automatic test_timeout();
        do_reset();
        coin(2'b01);
`ifdef COIN_TIMEOUT_EN
        repeat (7) step();
        checks++; if (change_valid !== 1'b0 || state_dbg !== ST_COLLECT || amount !== 6'd2) begin
            errors++; $display("FAIL timeout_early cv=%0b state=%0d amount=%0d exp 0/1/2", change_valid, state_dbg, amount); end
        step();
        checks++; if (change_valid !== 1'b1 || change_amt !== 6'd2 || amount !== 6'd0 || state_dbg !== ST_REFUND) begin
            errors++; $display("FAIL timeout_refund cv=%0b amt=%0d amount=%0d state=%0d exp 1/2/0/4",
                               change_valid, change_amt, amount, state_dbg); end
`else
        repeat (20) begin
            step();
            checks++; if (change_valid !== 1'b0 || amount !== 6'd2 || state_dbg !== ST_COLLECT) begin
                errors++; $display("FAIL hold_credit cv=%0b amount=%0d state=%0d exp 0/2/1", change_valid, amount, state_dbg); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_vend();
        test_insufficient();
        test_saturation();
        test_cancel();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
